// File: rtl/fpu_defs.sv
// Shared definitions for the FPU exception accumulator: flag layout, trap cause
// encodings, controller state type and the cause priority encoder.
package fpu_defs;

    localparam int C_FFLAG_W  = 4;
    localparam int C_FFLAG_IV = 3;
    localparam int C_FFLAG_OF = 2;
    localparam int C_FFLAG_UF = 1;
    localparam int C_FFLAG_IX = 0;

    localparam logic [1:0] C_CAUSE_IV = 2'd3;
    localparam logic [1:0] C_CAUSE_OF = 2'd2;
    localparam logic [1:0] C_CAUSE_UF = 2'd1;
    localparam logic [1:0] C_CAUSE_IX = 2'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } fpexc_state_e;

    // Highest-priority set flag wins; an all-zero input maps to the IX code.
    function automatic logic [1:0] trap_cause(input logic [C_FFLAG_W-1:0] f);
        logic [1:0] c;
        c = C_CAUSE_IX;
        if (f[C_FFLAG_UF]) c = C_CAUSE_UF;
        if (f[C_FFLAG_OF]) c = C_CAUSE_OF;
        if (f[C_FFLAG_IV]) c = C_CAUSE_IV;
        return c;
    endfunction

endpackage

// File: rtl/fpexc_satcnt.sv
// Saturating up-counter with synchronous clear; a clear and an increment in the
// same cycle leave the counter at one so the new event is not dropped.
module fpexc_satcnt #(
    parameter int C_CNT_W = 8
) (
    input  logic               Clk_CI,
    input  logic               Rst_RI,
    input  logic               Clr_SI,
    input  logic               Inc_SI,
    output logic [C_CNT_W-1:0] Cnt_DO
);

    logic [C_CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (Clr_SI) cnt_d = '0;
        if (Inc_SI && !(&cnt_d)) cnt_d = cnt_d + C_CNT_W'(1);
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign Cnt_DO = cnt_q;

endmodule

// File: rtl/fpexc_accum.sv
// Accrues FPU exception flags into a CSR-visible register, counts invalid
// operations and raises a trap when an accepted flag set hits the enable mask.
module fpexc_accum
    import fpu_defs::*;
#(
    parameter int C_CNT_W = 8
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic                 FlagValid_SI,
    output logic                 FlagReady_SO,
    input  logic                 IV_SI,
    input  logic                 OF_SI,
    input  logic                 UF_SI,
    input  logic                 IX_SI,
    input  logic                 CsrWrEn_SI,
    input  logic [C_FFLAG_W-1:0] CsrWrData_DI,
    input  logic                 CsrClr_SI,
    input  logic [C_FFLAG_W-1:0] CsrClrMask_DI,
    input  logic                 MaskWrEn_SI,
    input  logic [C_FFLAG_W-1:0] MaskWrData_DI,
    output logic [C_FFLAG_W-1:0] CsrRdData_DO,
    output logic [C_FFLAG_W-1:0] Mask_DO,
    output logic [C_CNT_W-1:0]   IvCnt_DO,
    output logic                 Trap_SO,
    output logic [1:0]           TrapCause_DO,
    input  logic                 TrapAck_SI
);

    fpexc_state_e         state_d, state_q;
    logic [C_FFLAG_W-1:0] fflags_d, fflags_q;
    logic [C_FFLAG_W-1:0] mask_d, mask_q;
    logic [1:0]           cause_d, cause_q;
    logic [C_FFLAG_W-1:0] flags_in, flags_en;
    logic                 accept;

    always_comb begin
        flags_in             = '0;
        flags_in[C_FFLAG_IV] = IV_SI;
        flags_in[C_FFLAG_OF] = OF_SI;
        flags_in[C_FFLAG_UF] = UF_SI;
        flags_in[C_FFLAG_IX] = IX_SI;
        accept   = FlagValid_SI && (state_q == ST_IDLE);
        flags_en = flags_in & mask_q;

        // Clear, then write, then OR accepted flags so a new flag always survives.
        fflags_d = fflags_q;
        if (CsrClr_SI)  fflags_d = fflags_d & ~CsrClrMask_DI;
        if (CsrWrEn_SI) fflags_d = CsrWrData_DI;
        if (accept)     fflags_d = fflags_d | flags_in;

        mask_d = MaskWrEn_SI ? MaskWrData_DI : mask_q;

        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (flags_en != '0)) begin
                    state_d = ST_TRAP;
                    cause_d = trap_cause(flags_en);
                end
            end
            ST_TRAP: begin
                if (TrapAck_SI) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q  <= ST_IDLE;
            fflags_q <= '0;
            mask_q   <= '0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            fflags_q <= fflags_d;
            mask_q   <= mask_d;
            cause_q  <= cause_d;
        end
    end

    fpexc_satcnt #(
        .C_CNT_W (C_CNT_W)
    ) i_ivcnt (
        .Clk_CI  (Clk_CI),
        .Rst_RI  (Rst_RI),
        .Clr_SI  (CsrClr_SI && CsrClrMask_DI[C_FFLAG_IV]),
        .Inc_SI  (accept && IV_SI),
        .Cnt_DO  (IvCnt_DO)
    );

    assign FlagReady_SO = (state_q == ST_IDLE);
    assign Trap_SO      = (state_q == ST_TRAP);
    assign TrapCause_DO = cause_q;
    assign CsrRdData_DO = fflags_q;
    assign Mask_DO      = mask_q;

endmodule

// File: tb/tb_fpexc_accum.sv
// Bench for fpexc_accum: directed vector table, hand-built corner sequences and
// randomized traffic against a flag-level reference model.
module tb_fpexc_accum;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, valid, iv, of_f, uf, ix, we, clr, mwe, ack;
    logic [3:0]    wd, cm, md;
    logic          ready, trap;
    logic [3:0]    rd, mask;
    logic [CW-1:0] cnt;
    logic [1:0]    cause;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_acc, m_mask, m_cnt, m_cause;
    bit m_trap;

    always #5 clk = ~clk;

    fpexc_accum #(.C_CNT_W(CW)) dut (
        .Clk_CI        (clk),
        .Rst_RI        (rst),
        .FlagValid_SI  (valid),
        .FlagReady_SO  (ready),
        .IV_SI         (iv),
        .OF_SI         (of_f),
        .UF_SI         (uf),
        .IX_SI         (ix),
        .CsrWrEn_SI    (we),
        .CsrWrData_DI  (wd),
        .CsrClr_SI     (clr),
        .CsrClrMask_DI (cm),
        .MaskWrEn_SI   (mwe),
        .MaskWrData_DI (md),
        .CsrRdData_DO  (rd),
        .Mask_DO       (mask),
        .IvCnt_DO      (cnt),
        .Trap_SO       (trap),
        .TrapCause_DO  (cause),
        .TrapAck_SI    (ack)
    );

    typedef struct {
        bit       v, f_iv, f_of, f_uf, f_ix, w, c, mw, a;
        bit [3:0] wdat, cmask, mdat;
        bit [3:0] e_rd, e_mask;
        int       e_cnt;
        bit       e_trap;
        bit [1:0] e_cause;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; valid = 0; iv = 0; of_f = 0; uf = 0; ix = 0;
        we = 0; wd = 0; clr = 0; cm = 0; mwe = 0; md = 0; ack = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int flags, en, old_mask;
        bit acc_ok;
        if (rst) begin
            m_acc = 0; m_mask = 0; m_cnt = 0; m_trap = 0; m_cause = 0;
            return;
        end
        flags    = iv * 8 + of_f * 4 + uf * 2 + ix;
        acc_ok   = valid && !m_trap;
        old_mask = m_mask;
        if (clr) m_acc = m_acc & ~int'(cm);
        if (we)  m_acc = int'(wd);
        if (acc_ok) m_acc = m_acc | flags;
        if (clr && cm[3]) m_cnt = 0;
        if (acc_ok && iv && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        if (mwe) m_mask = int'(md);
        en = flags & old_mask;
        if (!m_trap) begin
            if (acc_ok && en != 0) begin
                m_trap = 1;
                if (en >= 8)      m_cause = 3;
                else if (en >= 4) m_cause = 2;
                else if (en >= 2) m_cause = 1;
                else              m_cause = 0;
            end
        end else if (ack) begin
            m_trap = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rd"},    rd,    m_acc);
        check({tag, "_mask"},  mask,  m_mask);
        check({tag, "_cnt"},   cnt,   m_cnt);
        check({tag, "_trap"},  trap,  m_trap);
        check({tag, "_ready"}, ready, !m_trap);
        if (m_trap) check({tag, "_cause"}, cause, m_cause);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    vec_t tbl[12];

    initial begin
        // v iv of uf ix  w c mw a  wdat cmask mdat  e_rd e_mask cnt trap cause
        tbl[0]  = '{1,1,0,0,1, 0,0,0,0, 4'h0,4'h0,4'h0, 4'b1001,4'h0,1,0,2'd0};
        tbl[1]  = '{0,0,0,0,0, 0,0,1,0, 4'h0,4'h0,4'h4, 4'b1001,4'h4,1,0,2'd0};
        tbl[2]  = '{1,0,1,1,0, 0,0,0,0, 4'h0,4'h0,4'h0, 4'hF,   4'h4,1,1,2'd2};
        tbl[3]  = '{1,1,0,0,0, 0,0,1,0, 4'h0,4'h0,4'hF, 4'hF,   4'hF,1,1,2'd2};
        tbl[4]  = '{0,0,0,0,0, 0,0,0,1, 4'h0,4'h0,4'h0, 4'hF,   4'hF,1,0,2'd0};
        tbl[5]  = '{0,0,0,0,0, 0,0,0,1, 4'h0,4'h0,4'h0, 4'hF,   4'hF,1,0,2'd0};
        tbl[6]  = '{1,0,0,1,0, 1,1,1,0, 4'h0,4'hF,4'h0, 4'b0010,4'h0,0,1,2'd1};
        tbl[7]  = '{0,0,0,0,0, 0,0,0,1, 4'h0,4'h0,4'h0, 4'b0010,4'h0,0,0,2'd0};
        tbl[8]  = '{0,0,0,0,0, 0,1,0,0, 4'h0,4'h2,4'h0, 4'h0,   4'h0,0,0,2'd0};
        tbl[9]  = '{0,0,0,0,0, 1,0,0,0, 4'hC,4'h0,4'h0, 4'hC,   4'h0,0,0,2'd0};
        tbl[10] = '{1,1,0,0,0, 0,0,0,0, 4'h0,4'h0,4'h0, 4'hC,   4'h0,1,0,2'd0};
        tbl[11] = '{0,0,0,0,0, 0,1,0,0, 4'h0,4'h8,4'h0, 4'h4,   4'h0,0,0,2'd0};

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_rd", rd, 0);
        check("rst_mask", mask, 0);
        check("rst_cnt", cnt, 0);
        check("rst_trap", trap, 0);
        check("rst_cause", cause, 0);
        check("rst_ready", ready, 1);

        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            valid = tbl[i].v; iv = tbl[i].f_iv; of_f = tbl[i].f_of;
            uf = tbl[i].f_uf; ix = tbl[i].f_ix;
            we = tbl[i].w; wd = tbl[i].wdat; clr = tbl[i].c; cm = tbl[i].cmask;
            mwe = tbl[i].mw; md = tbl[i].mdat; ack = tbl[i].a;
            tick();
            check($sformatf("vec%0d_rd", i), rd, tbl[i].e_rd);
            check($sformatf("vec%0d_mask", i), mask, tbl[i].e_mask);
            check($sformatf("vec%0d_cnt", i), cnt, tbl[i].e_cnt);
            check($sformatf("vec%0d_trap", i), trap, tbl[i].e_trap);
            check($sformatf("vec%0d_ready", i), ready, !tbl[i].e_trap);
            if (tbl[i].e_trap) check($sformatf("vec%0d_cause", i), cause, tbl[i].e_cause);
        end

        // Counter saturation at all-ones
        do_reset();
        idle_inputs();
        valid = 1; iv = 1;
        repeat (255) tick();
        check("sat_255", cnt, 255);
        tick();
        check("sat_hold", cnt, 255);
        check("sat_rd", rd, 4'b1000);

        // Reset while trapping, with every other input active
        do_reset();
        idle_inputs();
        we = 1; wd = 4'hF; mwe = 1; md = 4'hF;
        tick();
        idle_inputs();
        valid = 1; iv = 1;
        tick();
        check("rtrap_trap", trap, 1);
        check("rtrap_cause", cause, 3);
        check("rtrap_rd", rd, 4'hF);
        rst = 1; valid = 1; of_f = 1; we = 1; wd = 4'hA; clr = 1; cm = 4'h1;
        mwe = 1; md = 4'h5; ack = 1;
        tick();
        check("rtrap_rd0", rd, 0);
        check("rtrap_mask0", mask, 0);
        check("rtrap_cnt0", cnt, 0);
        check("rtrap_trap0", trap, 0);
        check("rtrap_cause0", cause, 0);
        check("rtrap_ready1", ready, 1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            rst   = ($urandom_range(0, 79) == 0);
            valid = ($urandom_range(0, 2) != 0);
            iv    = ($urandom_range(0, 3) == 0);
            of_f  = ($urandom_range(0, 3) == 0);
            uf    = ($urandom_range(0, 3) == 0);
            ix    = ($urandom_range(0, 2) == 0);
            we    = ($urandom_range(0, 11) == 0);
            wd    = 4'($urandom);
            clr   = ($urandom_range(0, 9) == 0);
            cm    = 4'($urandom);
            mwe   = ($urandom_range(0, 7) == 0);
            md    = 4'($urandom) & 4'($urandom);
            ack   = ($urandom_range(0, 3) == 0);
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
